cpu_core: RTL and testbench

- Minimal multi-cycle 16-bit load/store CPU with internal unified instruction/data memory.
- It is the top of the CPU design and has only clock and reset pins.
- The bench preloads the program into the memory array by hierarchical reference using $readmemb, then observes internal state through the VCD dump.

---
 rtl/cpu_core.sv | 121 ++++++++++++
 tb/tb_cpu_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Minimal multi-cycle 16-bit load/store CPU with a unified 256-word instruction/data memory.
// FETCH -> EXEC (-> WB for loads) per instruction; HALT parks the core until reset.
module cpu_core #(
  parameter int MEM_DEPTH = 256,
  parameter int NUM_REGS  = 8
) (
  input logic clk,
  input logic rst
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] WB    = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [15:0] mem  [0:MEM_DEPTH-1];
  logic [15:0] regs [0:NUM_REGS-1];
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] mdr;
  logic [1:0]  state;
  logic        halted;

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [7:0]  imm8;
  logic [15:0] simm;
  logic [15:0] rdv, rsv, rtv;
  logic [7:0]  addr;
  logic        wr_en;
  logic [15:0] wr_data;

  assign op   = ir[15:12];
  assign rd   = ir[11:9];
  assign rs   = ir[8:6];
  assign rt   = ir[5:3];
  assign imm8 = ir[7:0];
  assign simm = {{8{imm8[7]}}, imm8};
  assign rdv  = regs[rd];
  assign rsv  = regs[rs];
  assign rtv  = regs[rt];
  assign addr = rsv[7:0];

  // Register-writing instructions that complete in EXEC; operands are sampled before the write.
  always_comb begin
    wr_en   = 1'b1;
    wr_data = 16'h0000;
    case (op)
      OP_LDI:  wr_data = {8'h00, imm8};
      OP_ADD:  wr_data = rsv + rtv;
      OP_SUB:  wr_data = rsv - rtv;
      OP_AND:  wr_data = rsv & rtv;
      OP_OR:   wr_data = rsv | rtv;
      OP_XOR:  wr_data = rsv ^ rtv;
      OP_MOV:  wr_data = rsv;
      OP_ADDI: wr_data = rdv + simm;
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= 8'h00;
      ir     <= 16'h0000;
      mdr    <= 16'h0000;
      state  <= FETCH;
      halted <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          ir    <= mem[pc];
          pc    <= pc + 8'd1;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          if (wr_en) regs[rd] <= wr_data;
          case (op)
            OP_LD: begin
              mdr   <= mem[addr];
              state <= WB;
            end
            OP_JMP:  pc <= imm8;
            OP_BEQZ: if (rdv == 16'h0000) pc <= imm8;
            OP_HALT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: ;
          endcase
        end
        WB: begin
          regs[rd] <= mdr;
          state    <= FETCH;
        end
        default: ;
      endcase
    end
  end

  // The write port is gated by rst so a store in flight when reset arrives never lands.
  always @(posedge clk) begin
    if (!rst && state == EXEC && op == OP_ST) mem[addr] <= rdv;
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: table of small programs with a scoreboard of expected
// architectural state, plus hand-written sequences for reset, halt hold and mid-run reset.
module tb_cpu_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cpu_core dut (
    .clk(clk),
    .rst(rst)
  );

  localparam int K_REG = 0;
  localparam int K_MEM = 1;
  localparam int K_PC  = 2;
  localparam int K_CYC = 3;
  localparam int K_HLT = 4;

  typedef struct {
    int          vec;
    logic [7:0]  addr;
    logic [15:0] word;
  } load_t;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] val;
    string       name;
  } exp_t;

  typedef struct {
    int vec;
    exp_t e;
  } vexp_t;

  typedef struct {
    string name;
    int    cycles;
    int    pc;
  } vec_t;

  load_t loads[$];
  vexp_t exps[$];
  vec_t  vecs[$];
  exp_t  sb[$];

  int tests = 0;
  int fails = 0;
  int cycles = 0;

  function automatic logic [15:0] fR(int op, int rd, int rs, int rt);
    return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] fI(int op, int rd, int imm);
    return {op[3:0], rd[2:0], 1'b0, imm[7:0]};
  endfunction

  function automatic void addLoad(int v, int a, logic [15:0] w);
    load_t l;
    l.vec = v; l.addr = a[7:0]; l.word = w;
    loads.push_back(l);
  endfunction

  function automatic void addExp(int v, int k, int i, logic [15:0] val, string n);
    vexp_t x;
    x.vec = v; x.e.kind = k; x.e.idx = i; x.e.val = val; x.e.name = n;
    exps.push_back(x);
  endfunction

  function automatic void addVec(string n, int cyc, int p);
    vec_t x;
    x.name = n; x.cycles = cyc; x.pc = p;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic runToHalt(input int budget);
    cycles = 0;
    while (dut.halted !== 1'b1 && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (dut.halted !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL halt_timeout: got no halt after %0d cycles, expected halt", cycles);
    end
  endtask

  task automatic loadProgram(input int v);
    rst = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 256; a++) dut.mem[a[7:0]] = 16'h0000;
    foreach (loads[i]) if (loads[i].vec == v) dut.mem[loads[i].addr] = loads[i].word;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int v);
    exp_t e;
    loadProgram(v);
    foreach (exps[i]) if (exps[i].vec == v) sb.push_back(exps[i].e);
    e.kind = K_CYC; e.idx = 0; e.val = vecs[v].cycles[15:0]; e.name = {vecs[v].name, "_cycles"};
    sb.push_back(e);
    e.kind = K_PC; e.val = vecs[v].pc[15:0]; e.name = {vecs[v].name, "_pc"};
    sb.push_back(e);
    e.kind = K_HLT; e.val = 16'h0001; e.name = {vecs[v].name, "_halted"};
    sb.push_back(e);
    rst = 1'b0;
    runToHalt(500);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [15:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REG:   act = dut.regs[e.idx[2:0]];
        K_MEM:   act = dut.mem[e.idx[7:0]];
        K_PC:    act = {8'h00, dut.pc};
        K_CYC:   act = cycles[15:0];
        default: act = {15'h0000, dut.halted};
      endcase
      check(e.name, act, e.val);
    end
  endtask

  initial begin
    logic [7:0] held_pc;

    // vec 0: basic add
    addVec("add", 8, 4);
    addLoad(0, 0, fI(1, 1, 5));
    addLoad(0, 1, fI(1, 2, 7));
    addLoad(0, 2, fR(2, 3, 1, 2));
    addLoad(0, 3, fI(15, 0, 0));
    addExp(0, K_REG, 3, 16'd12, "add_r3");

    // vec 1: subtract wrap, move, negative immediate
    addVec("subwrap", 12, 6);
    addLoad(1, 0, fI(1, 1, 0));
    addLoad(1, 1, fI(1, 2, 1));
    addLoad(1, 2, fR(3, 3, 1, 2));
    addLoad(1, 3, fR(11, 5, 3, 0));
    addLoad(1, 4, fI(12, 3, 8'hFF));
    addLoad(1, 5, fI(15, 0, 0));
    addExp(1, K_REG, 5, 16'hFFFF, "sub_r5");
    addExp(1, K_REG, 3, 16'hFFFE, "addi_r3");

    // vec 2: store/load round trip, LD costs an extra cycle
    addVec("memrt", 11, 5);
    addLoad(2, 0, fI(1, 1, 8'h80));
    addLoad(2, 1, fI(1, 2, 8'hA5));
    addLoad(2, 2, fR(8, 2, 1, 0));
    addLoad(2, 3, fR(7, 4, 1, 0));
    addLoad(2, 4, fI(15, 0, 0));
    addExp(2, K_MEM, 128, 16'h00A5, "st_mem128");
    addExp(2, K_REG, 4, 16'h00A5, "ld_r4");

    // vec 3: counted loop
    addVec("loop", 26, 6);
    addLoad(3, 0, fI(1, 1, 3));
    addLoad(3, 1, fI(12, 1, 8'hFF));
    addLoad(3, 2, fI(12, 2, 1));
    addLoad(3, 3, fI(10, 1, 5));
    addLoad(3, 4, fI(9, 0, 1));
    addLoad(3, 5, fI(15, 0, 0));
    addExp(3, K_REG, 1, 16'h0000, "loop_r1");
    addExp(3, K_REG, 2, 16'h0003, "loop_iters");

    // vec 4: logic ops, MOV into R0
    addVec("logic", 16, 8);
    addLoad(4, 0, fI(1, 1, 8'hF0));
    addLoad(4, 1, fI(1, 2, 8'h3C));
    addLoad(4, 2, fR(4, 3, 1, 2));
    addLoad(4, 3, fR(5, 4, 1, 2));
    addLoad(4, 4, fR(6, 5, 1, 2));
    addLoad(4, 5, fR(11, 6, 1, 0));
    addLoad(4, 6, fR(11, 0, 2, 0));
    addLoad(4, 7, fI(15, 0, 0));
    addExp(4, K_REG, 3, 16'h0030, "and_r3");
    addExp(4, K_REG, 4, 16'h00FC, "or_r4");
    addExp(4, K_REG, 5, 16'h00CC, "xor_r5");
    addExp(4, K_REG, 6, 16'h00F0, "mov_r6");
    addExp(4, K_REG, 0, 16'h003C, "mov_r0");

    // vec 5: branch both ways, rd==rs aliasing, run through empty memory and wrap
    addVec("wrap", 18, 2);
    addLoad(5, 0, fI(10, 2, 3));
    addLoad(5, 1, fI(15, 0, 0));
    addLoad(5, 3, fI(1, 2, 1));
    addLoad(5, 4, fR(2, 2, 2, 2));
    addLoad(5, 5, fI(9, 0, 253));
    addLoad(5, 253, fI(12, 2, 8'hFD));
    addExp(5, K_REG, 2, 16'hFFFF, "wrap_r2");

    // vec 6: store over the next instruction, fetch must see the new word
    addVec("selfmod", 8, 4);
    addLoad(6, 0, fI(1, 1, 2));
    addLoad(6, 1, fR(8, 0, 1, 0));
    addLoad(6, 2, fI(1, 5, 8'h77));
    addLoad(6, 3, fI(15, 0, 0));
    addExp(6, K_MEM, 2, 16'h0000, "selfmod_mem2");
    addExp(6, K_REG, 5, 16'h0000, "selfmod_r5");

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", {8'h00, dut.pc}, 16'h0000);
    check("rst_ir", dut.ir, 16'h0000);
    check("rst_halted", {15'h0000, dut.halted}, 16'h0000);
    check("rst_state", {14'h0000, dut.state}, 16'h0000);
    check("rst_mdr", dut.mdr, 16'h0000);

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(v);
      checkOutput();
    end

    // HALT holds state, then an async pulse clears it before any edge
    held_pc = dut.pc;
    repeat (10) @(posedge clk);
    #1;
    check("halt_hold_pc", {8'h00, dut.pc}, {8'h00, held_pc});
    check("halt_hold_state", {14'h0000, dut.state}, 16'h0003);
    check("halt_hold_r5", dut.regs[5], 16'h0000);
    #2 rst = 1'b1;
    #1;
    check("pulse_halted", {15'h0000, dut.halted}, 16'h0000);
    check("pulse_state", {14'h0000, dut.state}, 16'h0000);

    // Mid-program asynchronous reset on the loop program
    loadProgram(3);
    rst = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_pc", {8'h00, dut.pc}, 16'h0000);
    check("mid_r1", dut.regs[1], 16'h0000);
    check("mid_r2", dut.regs[2], 16'h0000);
    check("mid_halted", {15'h0000, dut.halted}, 16'h0000);
    check("mid_mem1_kept", dut.mem[1], fI(12, 1, 8'hFF));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("restart_ir", dut.ir, fI(1, 1, 3));
    check("restart_pc", {8'h00, dut.pc}, 16'h0001);
    runToHalt(500);
    cycles++;
    check("restart_cycles", cycles[15:0], 16'd26);
    check("restart_iters", dut.regs[2], 16'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
